// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad front end.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [3:0] KEY_ENTER1 = 4'd14;
    localparam logic [3:0] KEY_ENTER2 = 4'd15;

    // Row-major keypad legend; row 3 carries the two operand-select keys.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = 4'd10;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = 4'd11;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = 4'd12;
            4'hC:    code = KEY_ENTER1;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_ENTER2;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous row lines; idles high like the pull-ups.
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw,
    output logic [3:0] synced
);

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 4'b1111;
            sync_reg <= 4'b1111;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
        end
    end

    assign synced = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with press/release debounce and key decode.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [31:0] number,
    output logic [1:0]  pressed
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);

    logic [3:0] rs;

    keypad_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .raw    (row_in),
        .synced (rs)
    );

    state_t            state_reg, state_next;
    logic [1:0]        col_reg, col_next;
    logic [1:0]        row_reg, row_next;
    logic [SCAN_W-1:0] scan_cnt_reg, scan_cnt_next;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
    logic [3:0]        number_reg, number_next;
    logic [1:0]        pressed_reg, pressed_next;

    logic [2:0] low_count;
    logic [1:0] low_row;
    logic [3:0] only_row;

    always_comb begin
        low_count = '0;
        low_row   = '0;
        for (int i = 0; i < 4; i++) begin
            if (!rs[i]) begin
                low_count = low_count + 3'd1;
                low_row   = 2'(i);
            end
        end
    end

    // The latched row alone low: anything else is bounce, release or a second key.
    assign only_row = ~(4'b0001 << row_reg);

    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        scan_cnt_next = scan_cnt_reg;
        db_cnt_next   = db_cnt_reg;
        number_next   = number_reg;
        pressed_next  = {1'b0, pressed_reg[0]};
        case (state_reg)
            SCAN: begin
                if (scan_cnt_reg == SCAN_LAST) begin
                    scan_cnt_next = '0;
                    if (low_count == 3'd1) begin
                        row_next    = low_row;
                        db_cnt_next = '0;
                        state_next  = DEBOUNCE;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end else begin
                    scan_cnt_next = scan_cnt_reg + SCAN_W'(1);
                end
            end
            DEBOUNCE: begin
                if (db_cnt_reg == DB_MAX) begin
                    number_next  = key_code(row_reg, col_reg);
                    pressed_next = 2'b11;
                    db_cnt_next  = '0;
                    state_next   = HELD;
                end else if (rs == only_row) begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end else begin
                    db_cnt_next   = '0;
                    scan_cnt_next = '0;
                    state_next    = SCAN;
                end
            end
            HELD: begin
                if (rs[row_reg]) begin
                    db_cnt_next = '0;
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (db_cnt_reg == DB_MAX) begin
                    pressed_next  = 2'b00;
                    col_next      = col_reg + 2'd1;
                    scan_cnt_next = '0;
                    db_cnt_next   = '0;
                    state_next    = SCAN;
                end else if (rs[row_reg]) begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end else begin
                    db_cnt_next = '0;
                    state_next  = HELD;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= SCAN;
            col_reg      <= '0;
            row_reg      <= '0;
            scan_cnt_reg <= '0;
            db_cnt_reg   <= '0;
            number_reg   <= '0;
            pressed_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            scan_cnt_reg <= scan_cnt_next;
            db_cnt_reg   <= db_cnt_next;
            number_reg   <= number_next;
            pressed_reg  <= pressed_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col_out[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    assign number  = 32'(number_reg);
    assign pressed = pressed_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized keypad presses against a timing/legend model, checked by a scoreboard monitor.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [31:0] number;
    logic [1:0]  pressed;

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .number  (number),
        .pressed (pressed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int cycle;
    } accept_t;

    // Keypad legend as printed on the keys, row-major.
    int code_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    logic [15:0] keys_down = '0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          check_scan_cols = 1'b0;
    bit          prev_p0 = 1'b0;
    int          reset_req = 0;
    int          reset_done = 0;
    int          drain_req = 0;
    int          drain_done = 0;
    logic [3:0]  exp_col;
    accept_t     acc_q [$];
    int          fall_q [$];

    // Passive switch matrix: a closed key pulls its row low only while its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            accept_t a;
            int      f;
            tests++;
            if ($countones(~col_out) != 1) begin
                fails++;
                $display("FAIL col_onehot cyc=%0d col_out=%b required exactly one low", cyc, col_out);
            end
            if (check_scan_cols) begin
                exp_col = ~(4'b0001 << ((cyc / SD) % 4));
                tests++;
                if (col_out !== exp_col || number !== 32'd0 || pressed !== 2'b00) begin
                    fails++;
                    $display("FAIL idle_scan cyc=%0d col_out=%b number=%0d pressed=%b required col_out=%b number=0 pressed=00",
                             cyc, col_out, number, pressed, exp_col);
                end
            end
            if (reset_req > reset_done) begin
                reset_done++;
                tests++;
                if (col_out !== 4'b1110 || number !== 32'd0 || pressed !== 2'b00) begin
                    fails++;
                    $display("FAIL reset_values col_out=%b number=%0d pressed=%b required 1110/0/00",
                             col_out, number, pressed);
                end
            end
            if (pressed[1]) begin
                tests++;
                if (!pressed[0] || prev_p0) begin
                    fails++;
                    $display("FAIL pulse_level cyc=%0d pressed=%b prev_p0=%b required pulse only on rising p0",
                             cyc, pressed, prev_p0);
                end
                tests++;
                if (acc_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_accept cyc=%0d number=%0d required no accept", cyc, number);
                end else begin
                    a = acc_q.pop_front();
                    if (number !== 32'(a.code) || (a.cycle >= 0 && cyc != a.cycle)) begin
                        fails++;
                        $display("FAIL accept got code=%0d cyc=%0d required code=%0d cyc=%0d",
                                 number, cyc, a.code, a.cycle);
                    end else begin
                        $display("[TB] accept code=%0d cyc=%0d ok", number, cyc);
                    end
                end
            end
            if (prev_p0 && !pressed[0] && cyc != 0) begin
                tests++;
                if (fall_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_release cyc=%0d required pressed[0] held", cyc);
                end else begin
                    f = fall_q.pop_front();
                    if (f >= 0 && cyc != f) begin
                        fails++;
                        $display("FAIL release_time got cyc=%0d required cyc=%0d", cyc, f);
                    end else begin
                        $display("[TB] release cyc=%0d number=%0d ok", cyc, number);
                    end
                end
            end
            if (drain_req > drain_done) begin
                drain_done++;
                tests++;
                if (acc_q.size() != 0 || fall_q.size() != 0) begin
                    fails++;
                    $display("FAIL drain pending accepts=%0d releases=%0d required 0/0",
                             acc_q.size(), fall_q.size());
                end
            end
            prev_p0 = pressed[0];
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2000) begin
                $display("FAIL wait_cyc cyc=%0d target=%0d", cyc, n);
                $fatal(1);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Press one key from reset, hold, optionally glitch during release, then release.
    task automatic run_press(input int r, input int c, input int hold, input bit glitch);
        accept_t a;
        int      last;
        keys_down = '0;
        keys_down[r*4+c] = 1'b1;
        do_reset();
        a.code  = code_map[r*4+c];
        a.cycle = (c + 1) * SD + DB + 1;
        acc_q.push_back(a);
        $display("[TB] press r=%0d c=%0d hold=%0d glitch=%0d expect code=%0d at cyc=%0d",
                 r, c, hold, glitch, a.code, a.cycle);
        wait_cyc(hold);
        keys_down = '0;
        last = hold;
        if (glitch) begin
            wait_cyc(hold + 5);
            keys_down[r*4+c] = 1'b1;
            wait_cyc(hold + 7);
            keys_down = '0;
            last = hold + 7;
        end
        fall_q.push_back(last + DB + 4);
        wait_cyc(last + DB + 8);
        drain_req++;
    endtask

    initial begin
        accept_t a;
        keys_down = '0;

        // Idle scan from reset.
        do_reset();
        reset_req++;
        check_scan_cols = 1'b1;
        wait_cyc(20);
        check_scan_cols = 1'b0;
        drain_req++;

        // Key 6 held 40 cycles.
        run_press(1, 2, 40, 1'b0);

        // Bouncing key 14, then stable.
        keys_down = '0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            keys_down[12] = (k % 2 == 0);
            wait_cyc(3 * (k + 1));
        end
        keys_down[12] = 1'b1;
        a.code  = 14;
        a.cycle = -1;
        acc_q.push_back(a);
        wait_cyc(90);
        keys_down = '0;
        fall_q.push_back(90 + DB + 4);
        wait_cyc(90 + DB + 8);
        drain_req++;

        // Release glitch.
        run_press(2, 0, 40, 1'b1);

        // Ghosting on column 1: no accept, scan keeps moving.
        keys_down = '0;
        keys_down[1] = 1'b1;
        keys_down[9] = 1'b1;
        do_reset();
        check_scan_cols = 1'b1;
        wait_cyc(40);
        check_scan_cols = 1'b0;
        drain_req++;

        // Reset while key 15 is held; key is then re-accepted.
        keys_down = '0;
        keys_down[14] = 1'b1;
        do_reset();
        a.code  = 15;
        a.cycle = 3 * SD + DB + 1;
        acc_q.push_back(a);
        wait_cyc(25);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        reset_req++;
        acc_q.push_back(a);
        wait_cyc(50);
        keys_down = '0;
        fall_q.push_back(50 + DB + 4);
        wait_cyc(50 + DB + 8);
        drain_req++;

        // Random presses.
        for (int n = 0; n < 10; n++) begin
            run_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(30, 60)), bit'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
